// File: rtl/mod_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mod_counter_pkg
// Description : Shared state encoding and default width for the modulo counters.
// Revision    : 1.0
// ============================================================================
package mod_counter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int c_default_bits = 4;

endpackage : mod_counter_pkg
`default_nettype wire

// File: rtl/mod_counter_down_if.sv
`default_nettype none
// ============================================================================
// Module      : mod_counter_down_if
// Description : Control/status bundle between a timer user and mod_counter_down.
// Revision    : 1.0
// ============================================================================
interface mod_counter_down_if #(
    parameter int BITS = mod_counter_pkg::c_default_bits
);
    logic            enable;
    logic            start;
    logic            stop;
    logic [BITS-1:0] FINAL_VALUE;
    logic [BITS-1:0] Q;
    logic            busy;
    logic            done;

    modport master (
        output enable, start, stop, FINAL_VALUE,
        input  Q, busy, done
    );

    modport slave (
        input  enable, start, stop, FINAL_VALUE,
        output Q, busy, done
    );
endinterface : mod_counter_down_if
`default_nettype wire

// File: rtl/mod_counter_down.sv
`default_nettype none
// ============================================================================
// Module      : mod_counter_down
// Description : Programmable modulo down-counter with start/stop and a
//               terminal-count tick. Define MOD_COUNTER_DOWN_RELOAD_EN for
//               periodic auto-reload; otherwise it runs one-shot.
// Revision    : 1.0
// ============================================================================
module mod_counter_down
    import mod_counter_pkg::*;
#(
    parameter int BITS = c_default_bits
) (
    input  wire logic        clk,
    input  wire logic        reset,
    mod_counter_down_if.slave bus
);

    localparam logic [BITS-1:0] c_zero = '0;
    localparam logic [BITS-1:0] c_one  = {{(BITS-1){1'b0}}, 1'b1};

    state_t          r_state;
    logic [BITS-1:0] r_q;
    logic            r_busy;

    logic            w_at_zero;
    logic            w_step;
    logic            w_done;

    // ---------------- next-state qualifiers ----------------
    assign w_at_zero = (r_q == c_zero);
    assign w_step    = (r_state == RUN) && bus.enable && !bus.stop && !bus.start;
    assign w_done    = w_step && w_at_zero;

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_q     <= c_zero;
            r_busy  <= 1'b0;
        end else if (bus.stop) begin
            r_state <= IDLE;
            r_q     <= c_zero;
            r_busy  <= 1'b0;
        end else if (bus.start) begin
            r_state <= RUN;
            r_q     <= bus.FINAL_VALUE;
            r_busy  <= 1'b1;
        end else if (w_step) begin
            if (!w_at_zero) begin
                r_q <= r_q - c_one;
            end else begin
`ifdef MOD_COUNTER_DOWN_RELOAD_EN
                r_q     <= bus.FINAL_VALUE;
`else
                r_state <= IDLE;
                r_busy  <= 1'b0;
`endif
            end
        end
    end

    // ---------------- outputs ----------------
    assign bus.Q    = r_q;
    assign bus.busy = r_busy;
    assign bus.done = w_done;

endmodule : mod_counter_down
`default_nettype wire

// File: tb/tb_mod_counter_down.sv
`default_nettype none
// ============================================================================
// Module      : tb_mod_counter_down
// Description : Vector-table bench for mod_counter_down (both reload builds).
// Revision    : 1.0
// ============================================================================
module tb_mod_counter_down;
    import mod_counter_pkg::*;

    localparam int BITS = 4;

    typedef struct {
        logic            rst;
        logic            st;
        logic            sp;
        logic            en;
        logic [BITS-1:0] fv;
        logic            exp_done;
        logic [BITS-1:0] exp_q;
        logic            exp_busy;
    } vec_t;

    typedef struct {
        logic            d;
        logic [BITS-1:0] q;
        logic            b;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mod_counter_down_if #(.BITS(BITS)) bus ();

    mod_counter_down #(.BITS(BITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, req);
        end
    endtask

    task automatic add(input logic rst, input logic st, input logic sp, input logic en,
                       input int fv, input logic d, input int q, input logic b);
        vec_t v;
        v.rst = rst; v.st = st; v.sp = sp; v.en = en;
        v.fv = fv[BITS-1:0]; v.exp_done = d; v.exp_q = q[BITS-1:0]; v.exp_busy = b;
        vecs.push_back(v);
    endtask

    // Drive one cycle at posedge+1, check done mid-cycle and Q/busy after the edge.
    task automatic apply(input vec_t v, input string tag);
        exp_t e;
        reset           = v.rst;
        bus.start       = v.st;
        bus.stop        = v.sp;
        bus.enable      = v.en;
        bus.FINAL_VALUE = v.fv;
        e.d = v.exp_done; e.q = v.exp_q; e.b = v.exp_busy;
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        chk($sformatf("%s.done", tag), int'(bus.done), int'(e.d));
        @(posedge clk);
        #1;
        chk($sformatf("%s.Q", tag), int'(bus.Q), int'(e.q));
        chk($sformatf("%s.busy", tag), int'(bus.busy), int'(e.b));
    endtask

`ifdef MOD_COUNTER_DOWN_RELOAD_EN
    localparam logic RL = 1'b1;
`else
    localparam logic RL = 1'b0;
`endif

    initial begin
        reset = 1'b1; bus.start = 1'b0; bus.stop = 1'b0; bus.enable = 1'b0;
        bus.FINAL_VALUE = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.Q", int'(bus.Q), 0);
        chk("reset.busy", int'(bus.busy), 0);
        chk("reset.done", int'(bus.done), 0);

        //  rst st sp en fv  done Q  busy
        // one-shot 3,2,1,0 then terminal
        add(0, 1, 0, 1, 3, 0, 3, 1);
        add(0, 0, 0, 1, 3, 0, 2, 1);
        add(0, 0, 0, 1, 3, 0, 1, 1);
        add(0, 0, 0, 1, 3, 0, 0, 1);
        add(0, 0, 0, 1, 3, 1, RL ? 3 : 0, RL);
        add(0, 0, 0, 1, 3, 0, RL ? 2 : 0, RL);
        // enable toggling with FINAL_VALUE=2
        add(0, 1, 0, 0, 2, 0, 2, 1);
        add(0, 0, 0, 1, 2, 0, 1, 1);
        add(0, 0, 0, 0, 2, 0, 1, 1);
        add(0, 0, 0, 1, 2, 0, 0, 1);
        add(0, 0, 0, 0, 2, 0, 0, 1);
        add(0, 0, 0, 1, 2, 1, RL ? 2 : 0, RL);
        // stop+start together at Q=0 with enable
        add(0, 1, 0, 1, 1, 0, 1, 1);
        add(0, 0, 0, 1, 1, 0, 0, 1);
        add(0, 1, 1, 1, 5, 0, 0, 0);
        // restart in RUN at Q=1 with new value; later FINAL_VALUE edits ignored
        add(0, 1, 0, 1, 2, 0, 2, 1);
        add(0, 0, 0, 1, 2, 0, 1, 1);
        add(0, 1, 0, 1, 7, 0, 7, 1);
        add(0, 0, 0, 1, 3, 0, 6, 1);
        add(0, 0, 0, 1, 3, 0, 5, 1);
        // reset mid-count
        add(1, 0, 0, 1, 3, 0, 0, 0);
        // FINAL_VALUE=0: every enabled RUN cycle is terminal
        add(0, 1, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 1, 0, 1, 0, RL);
        add(0, 0, 0, 1, 0, RL, 0, RL);
        add(0, 0, 1, 0, 0, 0, 0, 0);
        // stop while idle keeps it idle
        add(0, 0, 1, 1, 4, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

`ifdef MOD_COUNTER_DOWN_RELOAD_EN
        begin
            vec_t v;
            int   mq;
            v.rst = 0; v.sp = 0; v.en = 1; v.fv = 2;
            v.st = 1; v.exp_done = 0; v.exp_q = 2; v.exp_busy = 1;
            apply(v, "rl.start");
            mq = 2;
            for (int k = 0; k < 9; k++) begin
                v.st = 0;
                v.exp_done = (mq == 0);
                mq = (mq == 0) ? 2 : mq - 1;
                v.exp_q = mq[BITS-1:0];
                v.exp_busy = 1;
                apply(v, $sformatf("rl.cyc%0d", k));
            end
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mod_counter_down
`default_nettype wire
